cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_pkg.sv | 25 ++
 rtl/cp0_unit.sv | 109 ++++++++++
 tb/tb_cp0_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId with interrupt and exception entry at commit.
// IntReq is combinational; register updates are visible one cycle later; no backpressure.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2020_0731
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend = (ExcCode != EXC_INT) & ~sr_exl;
    assign IntReq   = reset & (int_pend | exc_pend);

    // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
    assign epc_next = (BDIn ? (PC - 32'd4) : PC) & ~32'd3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_pend ? EXC_INT : ExcCode;
                cause_bd  <= BDIn;
                epc       <= epc_next;
            end else begin
                if (WE) begin
                    case (A2)
                        REG_SR: begin
                            sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
                            sr_exl <= DIn[SR_EXL];
                            sr_ie  <= DIn[SR_IE];
                        end
                        REG_CAUSE: begin
                            cause_bd  <= DIn[CAUSE_BD];
                            cause_exc <= DIn[CAUSE_EXC_HI:CAUSE_EXC_LO];
                        end
                        REG_EPC: epc <= DIn;
                        default: ;
                    endcase
                end
                // eret clearing EXL takes precedence over a concurrent SR write.
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sr_word                          = '0;
        sr_word[SR_IM_HI:SR_IM_LO]       = sr_im;
        sr_word[SR_EXL]                  = sr_exl;
        sr_word[SR_IE]                   = sr_ie;
        cause_word                       = '0;
        cause_word[CAUSE_BD]             = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = '0;
        endcase
    end

    assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: vector table plus hand-written sequences, post-edge results via a queue.
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam logic [31:0] PRID = 32'h2020_0731;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCode;
    logic [31:0] DIn, PC;
    logic        WE, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPCOut, DOut;

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BDIn(BDIn), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd;
        logic [5:0]  hw;
        logic        clr;
        logic [4:0]  a1;
        logic        irq;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] epc;
        int          idx;
    } exp_t;

    vec_t tbl[27];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic rst, logic we, logic [4:0] a2, logic [31:0] din,
                                logic [4:0] exc, logic [31:0] pc, logic bd, logic [5:0] hw,
                                logic clr, logic [4:0] a1, logic irq, logic [31:0] dout,
                                logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.we = we; v.a2 = a2; v.din = din; v.exc = exc; v.pc = pc;
        v.bd = bd; v.hw = hw; v.clr = clr; v.a1 = a1; v.irq = irq; v.dout = dout; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; WE = v.we; A2 = v.a2; DIn = v.din; ExcCode = v.exc; PC = v.pc;
        BDIn = v.bd; HWInt = v.hw; EXLClr = v.clr; A1 = v.a1;
    endtask

    task automatic edge_and_compare(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard[%0d]: queue empty, expected an entry", idx);
        end else begin
            e = sb.pop_front();
            check("dout", e.idx, DOut, e.dout);
            check("epc", e.idx, EPCOut, e.epc);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        check("intreq", idx, {31'd0, IntReq}, {31'd0, v.irq});
        e.dout = v.dout; e.epc = v.epc; e.idx = idx;
        sb.push_back(e);
        edge_and_compare(idx);
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        //         rst we a2        din           exc       pc           bd hw         clr a1         irq dout          epc
        tbl[0]  = mk(0, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_PRID,  0, PRID,         32'h0);
        tbl[1]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_SR,    0, 32'h0,        32'h0);
        tbl[2]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_CAUSE, 0, 32'h0,        32'h0);
        tbl[3]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_EPC,   0, 32'h0,        32'h0);
        tbl[4]  = mk(1, 1, REG_SR,   32'h0000_FC01, EXC_INT, 32'h0,       0, 6'b000000, 0, REG_SR,    0, 32'h0000_FC01, 32'h0);
        tbl[5]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h1002,    0, 6'b000100, 0, REG_CAUSE, 1, 32'h0000_1000, 32'h1000);
        tbl[6]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h2000,    0, 6'b000100, 0, REG_SR,    0, 32'h0000_FC03, 32'h1000);
        tbl[7]  = mk(1, 0, 5'd0,     32'h0,        EXC_ADEL, 32'h2000,    0, 6'b000100, 0, REG_CAUSE, 0, 32'h0000_1000, 32'h1000);
        tbl[8]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h2000,    0, 6'b000100, 1, REG_SR,    0, 32'h0000_FC01, 32'h1000);
        tbl[9]  = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h2004,    1, 6'b000100, 0, REG_EPC,   1, 32'h0000_2000, 32'h2000);
        tbl[10] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 1, REG_CAUSE, 0, 32'h8000_0000, 32'h2000);
        tbl[11] = mk(1, 0, 5'd0,     32'h0,        EXC_OV,   32'h3008,    1, 6'b000000, 0, REG_CAUSE, 1, 32'h8000_0030, 32'h3004);
        tbl[12] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 1, REG_SR,    0, 32'h0000_FC01, 32'h3004);
        tbl[13] = mk(1, 1, REG_EPC,  32'h1234_5678, EXC_OV,  32'h3010,    0, 6'b000000, 0, REG_EPC,   1, 32'h0000_3010, 32'h3010);
        tbl[14] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 1, REG_SR,    0, 32'h0000_FC01, 32'h3010);
        tbl[15] = mk(1, 0, 5'd0,     32'h0,        EXC_RI,   32'h4000,    0, 6'b000000, 1, REG_SR,    1, 32'h0000_FC03, 32'h4000);
        tbl[16] = mk(1, 1, REG_CAUSE, 32'hFFFF_FFFF, EXC_INT, 32'h0,      0, 6'b101010, 0, REG_CAUSE, 0, 32'h8000_A87C, 32'h4000);
        tbl[17] = mk(1, 1, REG_SR,   32'hFFFF_FFFF, EXC_INT, 32'h0,       0, 6'b000000, 0, REG_SR,    0, 32'h0000_FC03, 32'h4000);
        tbl[18] = mk(1, 1, REG_EPC,  32'hDEAD_BEEF, EXC_INT, 32'h0,       0, 6'b000000, 0, REG_EPC,   0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tbl[19] = mk(1, 1, REG_PRID, 32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_PRID,  0, PRID,         32'hDEAD_BEEF);
        tbl[20] = mk(1, 1, 5'd7,     32'hFFFF_FFFF, EXC_INT, 32'h0,       0, 6'b000000, 0, 5'd7,      0, 32'h0,        32'hDEAD_BEEF);
        tbl[21] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 1, REG_SR,    0, 32'h0000_FC01, 32'hDEAD_BEEF);
        tbl[22] = mk(1, 0, 5'd0,     32'h0,        EXC_ADES, 32'h0000_0002, 1, 6'b000000, 0, REG_EPC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        tbl[23] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 1, REG_SR,    0, 32'h0000_FC01, 32'hFFFF_FFFC);
        tbl[24] = mk(0, 1, REG_EPC,  32'h5555_5555, EXC_OV,  32'h6000,    0, 6'b111111, 1, REG_SR,    0, 32'h0,        32'h0);
        tbl[25] = mk(0, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b111111, 0, REG_CAUSE, 0, 32'h0,        32'h0);
        tbl[26] = mk(1, 0, 5'd0,     32'h0,        EXC_INT,  32'h0,       0, 6'b000000, 0, REG_CAUSE, 0, 32'h0,        32'h0);

        idle = mk(0, 0, 5'd0, 32'h0, EXC_INT, 32'h0, 0, 6'b0, 0, 5'd0, 0, 32'h0, 32'h0);
        drive(idle);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], i);
        end

        // No write-through: an SR write is not visible on DOut before the edge.
        @(negedge clk);
        idle.rst = 1'b1;
        drive(idle);
        WE = 1'b1; A2 = REG_SR; DIn = 32'h0000_FC01; A1 = REG_SR;
        #1;
        check("bypass", 100, DOut, 32'h0);
        e.dout = 32'h0000_FC01; e.epc = 32'h0; e.idx = 100;
        sb.push_back(e);
        edge_and_compare(100);

        // Interrupt entry with the line held: exactly one request, then masked by EXL.
        @(negedge clk);
        WE = 1'b0; HWInt = 6'b000001; PC = 32'h0000_5006; A1 = REG_SR;
        #1;
        check("held_irq", 101, {31'd0, IntReq}, 32'd1);
        e.dout = 32'h0000_FC03; e.epc = 32'h0000_5004; e.idx = 101;
        sb.push_back(e);
        edge_and_compare(101);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("held_masked", 102 + k, {31'd0, IntReq}, 32'd0);
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
